// File: rtl/csc_decoder.sv
// -----------------------------------------------------------------------------
// csc_decoder
//
// Rebuilds one dense, column-major activation matrix from the CSC-encoded iact
// streams and emits it one signed element per cycle, zero-filling the holes.
//
//   Address stream: start pointer of columns 1..W-1 (column 0 always starts at
//                   data word 0), all-ones marks an empty column, 0 terminates.
//   Data stream   : {value, row} words, ended by a {0,0} terminator word.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   start                 one-cycle pulse, begins a vector (only honoured idle)
//   matrix_height/width   H rows and W columns, latched at start
//   address_in_*          pointer stream (ready is combinational)
//   data_in_*             data word stream (ready is combinational)
//   dense_out_*           dense element stream with its row/col coordinates
//   dense_last            marks element (H-1, W-1)
//   busy                  high from start until vector_done
//   vector_done           one-cycle pulse once the data terminator is consumed
//   decode_error          sticky malformed-stream flag, cleared on start/reset
//
// The element stream has a single output register. A new element is loaded
// whenever that register is empty or being drained in the same cycle, which
// keeps one element per cycle under continuous ready and holds the presented
// element stable while dense_out_ready is low.
// -----------------------------------------------------------------------------
module csc_decoder #(
  parameter int ADDR_WIDTH  = 7,
  parameter int COUNT_WIDTH = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_COLS    = 31
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [4:0]                        matrix_height,
  input  logic [4:0]                        matrix_width,
  output logic                              address_in_ready,
  input  logic                              address_in_valid,
  input  logic [ADDR_WIDTH-1:0]             address_in,
  output logic                              data_in_ready,
  input  logic                              data_in_valid,
  input  logic [DATA_WIDTH+COUNT_WIDTH-1:0] data_in,
  input  logic                              dense_out_ready,
  output logic                              dense_out_valid,
  output logic signed [DATA_WIDTH-1:0]      dense_out,
  output logic [4:0]                        dense_row,
  output logic [4:0]                        dense_col,
  output logic                              dense_last,
  output logic                              busy,
  output logic                              vector_done,
  output logic                              decode_error
);

  localparam logic [ADDR_WIDTH-1:0] EMPTY_PTR = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEEK,
    EMIT,
    DRAIN
  } state_t;

  state_t                 state;
  logic [4:0]             h_m1;
  logic [4:0]             w_m1;
  logic [4:0]             k;
  logic [4:0]             scan;
  logic [4:0]             col;
  logic [4:0]             row;
  logic [ADDR_WIDTH-1:0]  data_idx;
  logic [ADDR_WIDTH-1:0]  next_ptr;
  logic                   term_seen;
  // Entry j holds the start pointer of column j+1.
  logic [ADDR_WIDTH-1:0]  ptr_table [MAX_COLS];

  function automatic logic ptr_is_empty(input logic [ADDR_WIDTH-1:0] p);
    return p == EMPTY_PTR;
  endfunction

  logic signed [DATA_WIDTH-1:0] head_val;
  logic [4:0]                   head_row;
  logic                         head_term;
  logic                         exhausted;
  logic                         hit;
  logic                         late;
  logic                         produce;
  logic                         slot_free;
  logic                         pop;
  logic                         row_last;
  logic                         col_last;

  assign head_val  = data_in[DATA_WIDTH+COUNT_WIDTH-1 -: DATA_WIDTH];
  assign head_row  = 5'(data_in[COUNT_WIDTH-1:0]);
  assign head_term = (head_val == '0);

  // The current column has no words left once the next column's start
  // pointer is reached, or the stream head is already the terminator.
  assign exhausted = (data_idx == next_ptr) | (data_in_valid & head_term);
  assign hit       = data_in_valid & ~exhausted & (head_row == row);
  // A head word whose row is behind the cursor can never be placed.
  assign late      = data_in_valid & ~exhausted & (head_row < row);
  // Without a head word we cannot tell a hole from a hit, so wait.
  assign produce   = exhausted | (data_in_valid & ~late);
  assign slot_free = ~dense_out_valid | dense_out_ready;
  assign row_last  = (row == h_m1);
  assign col_last  = (col == w_m1);

  always_comb begin
    address_in_ready = 1'b0;
    data_in_ready    = 1'b0;
    case (state)
      LOAD:    address_in_ready = 1'b1;
      EMIT:    data_in_ready    = (hit & slot_free) | late;
      DRAIN:   data_in_ready    = ~term_seen;
      default: ;
    endcase
  end

  assign pop = data_in_valid & data_in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      h_m1            <= '0;
      w_m1            <= '0;
      k               <= '0;
      scan            <= '0;
      col             <= '0;
      row             <= '0;
      data_idx        <= '0;
      next_ptr        <= EMPTY_PTR;
      term_seen       <= 1'b0;
      dense_out_valid <= 1'b0;
      dense_out       <= '0;
      dense_row       <= '0;
      dense_col       <= '0;
      dense_last      <= 1'b0;
      busy            <= 1'b0;
      vector_done     <= 1'b0;
      decode_error    <= 1'b0;
      for (int i = 0; i < MAX_COLS; i++) ptr_table[i] <= EMPTY_PTR;
    end else begin
      vector_done <= 1'b0;
      if (dense_out_valid & dense_out_ready) dense_out_valid <= 1'b0;

      case (state)
        // ---- idle: wait for start, latch geometry, clear pointer table ----
        IDLE: begin
          if (start) begin
            h_m1         <= matrix_height - 5'd1;
            w_m1         <= matrix_width - 5'd1;
            k            <= '0;
            col          <= '0;
            row          <= '0;
            data_idx     <= '0;
            term_seen    <= 1'b0;
            decode_error <= 1'b0;
            busy         <= 1'b1;
            for (int i = 0; i < MAX_COLS; i++) ptr_table[i] <= EMPTY_PTR;
            state        <= LOAD;
          end
        end

        // ---- load: capture column start pointers until the 0 terminator ----
        LOAD: begin
          if (address_in_valid) begin
            if (address_in == '0) begin
              col   <= '0;
              scan  <= '0;
              state <= SEEK;
            end else if (k < w_m1) begin
              ptr_table[k] <= address_in;
              k            <= k + 5'd1;
            end else begin
              decode_error <= 1'b1;
            end
          end
        end

        // ---- seek: find the next non-empty column start after this column ----
        SEEK: begin
          if (!ptr_is_empty(ptr_table[scan])) begin
            next_ptr <= ptr_table[scan];
            row      <= '0;
            state    <= EMIT;
          end else if (scan == w_m1) begin
            next_ptr <= EMPTY_PTR;
            row      <= '0;
            state    <= EMIT;
          end else begin
            scan <= scan + 5'd1;
          end
        end

        // ---- emit: one dense element per free output slot ----
        EMIT: begin
          if (pop) data_idx <= data_idx + ADDR_WIDTH'(1);
          if (late) decode_error <= 1'b1;
          if (produce & slot_free) begin
            dense_out_valid <= 1'b1;
            dense_out       <= hit ? head_val : '0;
            dense_row       <= row;
            dense_col       <= col;
            dense_last      <= row_last & col_last;
            if (row_last) begin
              row <= '0;
              if (col_last) begin
                state <= DRAIN;
              end else begin
                col   <= col + 5'd1;
                scan  <= col + 5'd1;
                state <= SEEK;
              end
            end else begin
              row <= row + 5'd1;
            end
          end
        end

        // ---- drain: consume up to the data terminator, then finish ----
        DRAIN: begin
          if (pop) begin
            data_idx <= data_idx + ADDR_WIDTH'(1);
            if (head_term) term_seen    <= 1'b1;
            else           decode_error <= 1'b1;
          end
          // Finish only once the last element has also left the output slot.
          if ((term_seen | (pop & head_term)) & slot_free) begin
            term_seen   <= 1'b0;
            busy        <= 1'b0;
            vector_done <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csc_decoder.sv
// -----------------------------------------------------------------------------
// tb_csc_decoder
//
// Directed bench for csc_decoder. Each vector is described by its address
// words, data words and the hand-computed dense matrix (column-major). The
// bench plays both streams, optionally throttles dense_out_ready, and checks
// every presented element, the done pulse and the final stream positions.
// -----------------------------------------------------------------------------
module tb_csc_decoder;

  logic        clock;
  logic        reset;
  logic        start;
  logic [4:0]  matrix_height;
  logic [4:0]  matrix_width;
  logic        address_in_ready;
  logic        address_in_valid;
  logic [6:0]  address_in;
  logic        data_in_ready;
  logic        data_in_valid;
  logic [11:0] data_in;
  logic        dense_out_ready;
  logic        dense_out_valid;
  logic signed [7:0] dense_out;
  logic [4:0]  dense_row;
  logic [4:0]  dense_col;
  logic        dense_last;
  logic        busy;
  logic        vector_done;
  logic        decode_error;

  csc_decoder dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .matrix_height    (matrix_height),
    .matrix_width     (matrix_width),
    .address_in_ready (address_in_ready),
    .address_in_valid (address_in_valid),
    .address_in       (address_in),
    .data_in_ready    (data_in_ready),
    .data_in_valid    (data_in_valid),
    .data_in          (data_in),
    .dense_out_ready  (dense_out_ready),
    .dense_out_valid  (dense_out_valid),
    .dense_out        (dense_out),
    .dense_row        (dense_row),
    .dense_col        (dense_col),
    .dense_last       (dense_last),
    .busy             (busy),
    .vector_done      (vector_done),
    .decode_error     (decode_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [6:0]        addr_q [0:7];
  logic [11:0]       data_q [0:7];
  logic signed [7:0] exp_q  [0:31];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 32; i++) exp_q[i] = 8'sd0;
  endtask

  task automatic load_case1();
    addr_q[0] = 7'd2;  addr_q[1] = 7'd0;
    data_q[0] = {8'd5, 4'd1};
    data_q[1] = {8'hFD, 4'd3};
    data_q[2] = {8'd7, 4'd0};
    data_q[3] = 12'h000;
    clear_exp();
    exp_q[1] = 8'sd5;
    exp_q[3] = -8'sd3;
    exp_q[4] = 8'sd7;
  endtask

  task automatic check_reset_state();
    @(negedge clock);
    check("rst_out_valid", 32'(dense_out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(vector_done), 32'd0);
    check("rst_error", 32'(decode_error), 32'd0);
    check("rst_addr_ready", 32'(address_in_ready), 32'd0);
    check("rst_data_ready", 32'(data_in_ready), 32'd0);
    check("rst_dense_out", 32'(dense_out), 32'd0);
    check("rst_last", 32'(dense_last), 32'd0);
  endtask

  // Plays one vector. bp throttles dense_out_ready randomly; abort_at > 0
  // stops after that many cycles; poke_start pulses start with bogus
  // geometry mid-run, which must be ignored.
  task automatic run_vec(input int h, input int w, input int na, input int nd,
                         input bit bp, input int abort_at, input bit poke_start,
                         input bit exp_err);
    int  ai, di, n, term_cyc;
    bit  a_fire, d_fire, o_fire, term_popped, done;
    ai = 0; di = 0; n = 0; term_cyc = -10;
    term_popped = 1'b0; done = 1'b0;

    @(posedge clock); #1;
    matrix_height = 5'(h);
    matrix_width  = 5'(w);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    address_in_valid = (na > 0);
    address_in       = addr_q[0];
    data_in_valid    = (nd > 0);
    data_in          = data_q[0];
    dense_out_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;

    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clock);
      if (cyc == 0) check("busy_after_start", 32'(busy), 32'd1);
      if (dense_out_valid) begin
        if (n < h * w) begin
          check("elem_value", 32'(dense_out), 32'(exp_q[n]));
          check("elem_row", 32'(dense_row), 32'(n % h));
          check("elem_col", 32'(dense_col), 32'(n / h));
          check("elem_last", 32'(dense_last), 32'(n == h * w - 1));
        end else begin
          check("extra_element", 32'(n), 32'(h * w - 1));
        end
      end
      a_fire = address_in_valid & address_in_ready;
      d_fire = data_in_valid & data_in_ready;
      o_fire = dense_out_valid & dense_out_ready;
      if (vector_done) begin
        check("done_after_all_elements", 32'(n), 32'(h * w));
        check("done_after_terminator", 32'(term_popped), 32'd1);
        if (!bp) check("done_latency", 32'(cyc), 32'(term_cyc + 1));
        done = 1'b1;
        break;
      end
      if (d_fire && di == nd - 1) begin
        term_popped = 1'b1;
        term_cyc    = cyc;
      end
      if (o_fire) n++;
      if (abort_at > 0 && cyc == abort_at) break;

      @(posedge clock); #1;
      if (a_fire) ai++;
      if (d_fire) di++;
      address_in_valid = (ai < na);
      address_in       = (ai < na) ? addr_q[ai] : 7'd0;
      data_in_valid    = (di < nd);
      data_in          = (di < nd) ? data_q[di] : 12'h000;
      dense_out_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_start && cyc == 3) begin
        start = 1'b1;
        matrix_height = 5'd1;
        matrix_width  = 5'd1;
      end else begin
        start = 1'b0;
      end
    end

    if (abort_at == 0) begin
      if (!done) check("timeout_vector_done", 32'd0, 32'd1);
      @(negedge clock);
      check("done_pulse_width", 32'(vector_done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
      check("decode_error", 32'(decode_error), 32'(exp_err));
      check("elements_seen", 32'(n), 32'(h * w));
      check("addr_words_taken", 32'(ai), 32'(na));
      check("data_words_taken", 32'(di + (term_popped ? 0 : 1)), 32'(nd));
    end
    start = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    start            = 1'b0;
    matrix_height    = 5'd0;
    matrix_width     = 5'd0;
    address_in_valid = 1'b0;
    address_in       = 7'd0;
    data_in_valid    = 1'b0;
    data_in          = 12'h000;
    dense_out_ready  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_state();
    @(posedge clock); #1;
    reset = 1'b0;

    // H=4, W=3: col0=[0,5,0,-3], col1=[7,0,0,0], col2 zeros
    load_case1();
    run_vec(4, 3, 2, 4, 1'b0, 0, 1'b0, 1'b0);

    // H=3, W=3 with an empty column 1; a stray start mid-run is ignored
    addr_q[0] = 7'h7F; addr_q[1] = 7'd1; addr_q[2] = 7'd0;
    data_q[0] = {8'd9, 4'd2};
    data_q[1] = {8'd4, 4'd1};
    data_q[2] = 12'h000;
    clear_exp();
    exp_q[2] = 8'sd9;
    exp_q[7] = 8'sd4;
    run_vec(3, 3, 3, 3, 1'b0, 0, 1'b1, 1'b0);

    // All-zero 2x2 vector
    addr_q[0] = 7'd0;
    data_q[0] = 12'h000;
    clear_exp();
    run_vec(2, 2, 1, 1, 1'b0, 0, 1'b0, 1'b0);

    // First case again under random backpressure
    load_case1();
    run_vec(4, 3, 2, 4, 1'b1, 0, 1'b0, 1'b0);

    // Out-of-order rows in a single 4-row column: 6 dropped, error raised
    addr_q[0] = 7'd0;
    data_q[0] = {8'd5, 4'd2};
    data_q[1] = {8'd6, 4'd1};
    data_q[2] = 12'h000;
    clear_exp();
    exp_q[2] = 8'sd5;
    run_vec(4, 1, 1, 3, 1'b0, 0, 1'b0, 1'b1);

    // Reset in the middle of emitting, then a clean decode
    load_case1();
    run_vec(4, 3, 2, 4, 1'b0, 8, 1'b0, 1'b0);
    @(posedge clock); #1;
    reset            = 1'b1;
    address_in_valid = 1'b0;
    data_in_valid    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_state();
    @(posedge clock); #1;
    reset = 1'b0;
    load_case1();
    run_vec(4, 3, 2, 4, 1'b0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csc_decoder.md
Name: csc_decoder

Overview:
- Reads one CSC-encoded activation vector back out of the iact address/data SRAM streams and rebuilds the dense, column-major matrix.
- Emits one signed element per cycle, with zero-fill, toward the pooling/debug path.
- Inverse of the CSC encoder's stream format:
  - Address stream: per-column start pointers, all-ones marks an empty column, 0 is the terminator.
  - Data stream: {value, row} words followed by a {0,0} terminator.

Parameters:
ADDR_WIDTH, 7, width of address word and data index counter
COUNT_WIDTH, 4, width of row-index field in data word
DATA_WIDTH, 8, width of signed value field
MAX_COLS, 31, depth of internal pointer table (columns 1..MAX_COLS)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begin decoding one vector (ignored unless idle)
matrix_height  in  5  rows per column H (1..2^COUNT_WIDTH), latched at start
matrix_width  in  5  columns W (1..MAX_COLS), latched at start
address_in_ready  out  1  pointer word accepted
address_in_valid  in  1  pointer word present
address_in  in  ADDR_WIDTH  start pointer / all-ones empty / 0 terminator
data_in_ready  out  1  data word popped
data_in_valid  in  1  data word present
data_in  in  DATA_WIDTH+COUNT_WIDTH  {value[DATA_WIDTH-1:0], row[COUNT_WIDTH-1:0]}
dense_out_ready  in  1  downstream accepts element
dense_out_valid  out  1  element present
dense_out  out  DATA_WIDTH  signed dense element
dense_row  out  5  row of dense_out
dense_col  out  5  column of dense_out
dense_last  out  1  high on element (H-1, W-1)
busy  out  1  high from start until vector_done
vector_done  out  1  one-cycle pulse after data terminator popped
decode_error  out  1  sticky; cleared on start or reset

Behaviour:
- Reset: FSM=IDLE. All outputs 0, all ready outputs 0. Pointer table filled with all-ones. col=row=data_idx=0.
- States IDLE -> LOAD -> SEEK -> EMIT -> (SEEK | DRAIN) -> IDLE.
- IDLE: start latches H, W, clears decode_error and table index k=0, goes to LOAD.
- LOAD:
  - address_in_ready=1. Each accepted nonzero word writes table[k], k++.
  - Accepted 0 (terminator): entries k..MAX_COLS-1 remain all-ones; go to SEEK with col=0.
  - Column 0 start is implicitly 0 and never sent.
  - More than W-1 nonzero words before terminator: set decode_error, discard the extras.
- SEEK:
  - Scans table from entry index col (i.e. column col+1) upward, one entry per cycle, for the first non-all-ones entry → next_ptr.
  - If none is found, next_ptr=all-ones (column ends only on data terminator).
  - Scan stops at index W-1. Then go to EMIT with row=0.
  - Latency 1..W cycles.
- EMIT:
  - dense_out_valid=1, dense_row=row, dense_col=col.
  - exhausted = (data_idx==next_ptr) | (data_in_valid & value==0).
  - Match = data_in_valid & ~exhausted & data_in.row==row.
    - dense_out=value; data_in_ready=dense_out_ready; data_idx++ on pop.
  - Otherwise dense_out=0 with no pop.
  - Head word with row<row and not exhausted: set decode_error and pop-drop it. No element is emitted that cycle.
  - data_in_valid=0 and not exhausted: dense_out_valid=0 (stall, never guess zero).
  - Beat accepted (valid&ready): row++. At row==H-1: row=0, col++. If col==W-1, go to DRAIN; else go to SEEK.
  - dense_out/row/col held stable while valid & ~ready.
- DRAIN:
  - data_in_ready=1.
  - Pops words until the terminator (value==0) is popped; any nonzero word popped here sets decode_error.
  - Then vector_done=1 for one cycle, busy=0, go to IDLE.
- Arithmetic: data_idx ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH. Row field compared zero-extended to 5 bits.
- start while busy: ignored. Reset mid-vector: immediate return to reset state, partial output discarded, no vector_done.
- Outputs are registered except the ready outputs, which are combinational from state and inputs.

Test Plan:
- H=4, W=3, addr {2,0}, data {5,r1},{-3,r3},{7,r0},{0,0} -> dense col0=[0,5,0,-3], col1=[7,0,0,0], col2=[0,0,0,0]; dense_last on (3,2); vector_done one cycle after terminator pop.
- H=3, W=3, addr {7F,1,0}, data {9,r2},{4,r1},{0,0} -> col0=[0,0,9], col1 all zero, col2=[0,4,0]; SEEK skips all-ones entry.
- All-zero vector H=2, W=2, addr {0}, data {0,0} -> four zero elements, decode_error=0.
- Backpressure: toggle dense_out_ready 50% on the first case -> identical sequence, fields stable while stalled, no data word popped twice.
- Out-of-order data {5,r2},{6,r1} in one column -> decode_error=1, value 6 dropped, 5 emitted at row 2.
- Reset asserted mid-EMIT then new start -> clean decode of the first case, no spurious vector_done.
